// File: rtl/mem_arbiter_pkg.sv
// Shared codes for the memory arbiter: controller access types, arbiter states, default line size.
package mem_arbiter_pkg;

  localparam int DEF_LINE_WORDS_LOG = 2;

  localparam logic [2:0] MC_TYPE_B = 3'b000;
  localparam logic [2:0] MC_TYPE_W = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_LS_BUSY = 2'd2,
    ARB_GAP     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller between IF line fills and single LS accesses.
// Fill = LINE_WORDS*(word+2) cycles, LS = access+2; requests held until done, controller stalls absorbed by holding mc_valid.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS_LOG = DEF_LINE_WORDS_LOG
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rdy,
  input  logic                              flush,
  input  logic                              if_req,
  input  logic [31:0]                       if_addr,
  output logic                              if_done,
  output logic [(32<<LINE_WORDS_LOG)-1:0]   if_line,
  input  logic                              ls_req,
  input  logic                              ls_wr,
  input  logic [31:0]                       ls_addr,
  input  logic [2:0]                        ls_type,
  input  logic [31:0]                       ls_data,
  output logic                              ls_done,
  output logic [31:0]                       ls_rdata,
  output logic                              mc_valid,
  output logic                              mc_wr,
  output logic [31:0]                       mc_addr,
  output logic [2:0]                        mc_type,
  output logic [31:0]                       mc_data,
  input  logic                              mc_ready,
  input  logic [31:0]                       mc_result
);

  localparam int OFS = LINE_WORDS_LOG + 2;

  arb_state_t                 state;
  logic                       fill_active;
  logic [LINE_WORDS_LOG-1:0]  idx;
  logic [31:OFS]              line_base;
  logic                       last_ls;
  logic                       fill_live;
  logic                       unused_addr_bits;

  // A flush in this cycle already kills the fill, so nothing may be granted or written for it.
  assign fill_live        = fill_active && !flush;
  assign unused_addr_bits = ^if_addr[OFS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      fill_active <= 1'b0;
      idx         <= '0;
      line_base   <= '0;
      last_ls     <= 1'b0;
      mc_valid    <= 1'b0;
      mc_wr       <= 1'b0;
      mc_addr     <= '0;
      mc_type     <= '0;
      mc_data     <= '0;
      if_done     <= 1'b0;
      if_line     <= '0;
      ls_done     <= 1'b0;
      ls_rdata    <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          // LS wins ties, except right after an LS access while a fill is still pending.
          if (ls_req && !(last_ls && fill_live)) begin
            state    <= ARB_LS_BUSY;
            mc_valid <= 1'b1;
            mc_wr    <= ls_wr;
            mc_addr  <= ls_addr;
            mc_type  <= ls_type;
            mc_data  <= ls_data;
            last_ls  <= 1'b1;
          end else if (fill_live) begin
            state    <= ARB_IF_BUSY;
            mc_valid <= 1'b1;
            mc_wr    <= 1'b0;
            mc_addr  <= {line_base, idx, 2'b00};
            mc_type  <= MC_TYPE_W;
            mc_data  <= '0;
            last_ls  <= 1'b0;
          end else if (if_req && !flush) begin
            state       <= ARB_IF_BUSY;
            fill_active <= 1'b1;
            line_base   <= if_addr[31:OFS];
            idx         <= '0;
            mc_valid    <= 1'b1;
            mc_wr       <= 1'b0;
            mc_addr     <= {if_addr[31:OFS], {LINE_WORDS_LOG{1'b0}}, 2'b00};
            mc_type     <= MC_TYPE_W;
            mc_data     <= '0;
            last_ls     <= 1'b0;
          end
        end
        ARB_IF_BUSY: begin
          // A word already issued must run to completion; after a flush its data is dropped.
          if (mc_ready) begin
            state    <= ARB_GAP;
            mc_valid <= 1'b0;
            if (fill_live) begin
              if_line[{idx, 5'd0} +: 32] <= mc_result;
              idx <= idx + 1'b1;
              if (idx == '1) begin
                if_done     <= 1'b1;
                fill_active <= 1'b0;
              end
            end
          end
        end
        ARB_LS_BUSY: begin
          if (mc_ready) begin
            state    <= ARB_GAP;
            mc_valid <= 1'b0;
            ls_rdata <= mc_result;
            ls_done  <= 1'b1;
          end
        end
        ARB_GAP: state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
      if (flush) begin
        fill_active <= 1'b0;
        idx         <= '0;
      end
    end
  end

endmodule
